// File: rtl/display_defs_pkg.sv
// Shared encodings and constants for the 7-segment scan controller.
package display_defs;
  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} estado_t;
  localparam logic [3:0] ANODOS_OFF  = 4'b1111;
  localparam logic [3:0] COD_BLANCO  = 4'hF;
  localparam int         NUM_DIGITOS = 4;
endpackage

// File: rtl/display_lz_blank.sv
// Splits a 4-digit value into per-digit codes, optionally blanking leading zeros.
module display_lz_blank
  import display_defs::*;
(
  input  logic [4*NUM_DIGITOS-1:0]      valor,
  input  logic                          supresion,
  output logic [NUM_DIGITOS-1:0][3:0]   codigos
);

  logic lead;

  // Digit 0 is never blanked so an all-zero value still shows "0".
  always_comb begin
    lead = supresion;
    for (int i = 0; i < NUM_DIGITOS; i++) codigos[i] = valor[4*i +: 4];
    for (int i = NUM_DIGITOS-1; i > 0; i--) begin
      lead = lead && (valor[4*i +: 4] == 4'h0);
      if (lead) codigos[i] = COD_BLANCO;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit scan with per-slot blanking and frame-synchronous updates.
module display_scan_ctrl
  import display_defs::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
)(
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] valor,
  input  logic        cargar,
  input  logic        supresion_ceros,
  output logic [3:0]  numero,
  output logic [3:0]  anodos,
  output logic        fin_cuadro
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  estado_t       st_q, st_d;
  logic [3:0]    numero_q, numero_d;
  logic [3:0]    anodos_q, anodos_d;
  logic [15:0]   pend_q, pend_d;
  logic [15:0]   act_q, act_d;
  logic [NUM_DIGITOS-1:0][3:0] codigos;

  // Fed with the next displayed value so a boundary load reaches digit 0 of the same frame.
  display_lz_blank u_lz (
    .valor     (act_d),
    .supresion (supresion_ceros),
    .codigos   (codigos)
  );

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    st_d     = st_q;
    numero_d = numero_q;
    pend_d   = pend_q;
    act_d    = act_q;

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    case (st_q)
      ST_BLANK: if (cnt_q == CNT_BLK) st_d = ST_SHOW;
      ST_SHOW:  if (cnt_q == CNT_MAX) st_d = ST_BLANK;
      default:  st_d = ST_BLANK;
    endcase

    if (cargar) pend_d = valor;
    if (cnt_q == '0 && idx_q == 2'd0) act_d = cargar ? valor : pend_q;
    // Code latched at slot start gives the decoder the whole blank interval to settle.
    if (cnt_q == '0) numero_d = codigos[idx_q];

    anodos_d = (st_d == ST_SHOW) ? ~(4'b0001 << idx_d) : ANODOS_OFF;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      st_q     <= ST_BLANK;
      numero_q <= COD_BLANCO;
      anodos_q <= ANODOS_OFF;
      pend_q   <= 16'h0000;
      act_q    <= 16'h0000;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      st_q     <= st_d;
      numero_q <= numero_d;
      anodos_q <= anodos_d;
      pend_q   <= pend_d;
      act_q    <= act_d;
    end
  end

  assign numero     = numero_q;
  assign anodos     = anodos_q;
  assign fin_cuadro = (idx_q == 2'd3) && (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl against a cycle-count reference model.
module tb_display_scan_ctrl;
  localparam int RD = 10;
  localparam int BL = 3;
  localparam int FR = 4 * RD;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] valor = 16'h0000;
  logic        cargar = 1'b0;
  logic        supr = 1'b0;
  logic [3:0]  numero, anodos;
  logic        fin_cuadro;

  int total = 0;
  int bad = 0;

  display_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .CLK             (CLK),
    .reset           (reset),
    .valor           (valor),
    .cargar          (cargar),
    .supresion_ceros (supr),
    .numero          (numero),
    .anodos          (anodos),
    .fin_cuadro      (fin_cuadro)
  );

  always #5 CLK = ~CLK;

  // Reference model: m_t counts cycles since reset release; slot/digit come from division.
  int          m_t = 0;
  logic [15:0] m_pend = 16'h0, m_act = 16'h0;
  logic [3:0]  m_num = 4'hF;

  function automatic logic [3:0] dig_code(input logic [15:0] v, input int i, input logic s);
    logic [15:0] tmp;
    tmp = v >> (4 * i);
    if (s && i > 0 && tmp == 16'h0) return 4'hF;
    return tmp[3:0];
  endfunction

  function automatic logic [3:0] exp_an(input int t);
    if ((t % RD) >= BL) return ~(4'b0001 << ((t / RD) % 4));
    return 4'hF;
  endfunction

  function automatic logic exp_fin(input int t);
    return ((t / RD) % 4 == 3) && ((t % RD) == RD - 1);
  endfunction

  always @(posedge CLK) begin : model
    int w, ix;
    logic [15:0] a;
    if (reset) begin
      m_t <= 0; m_pend <= 16'h0; m_act <= 16'h0; m_num <= 4'hF;
    end else begin
      w = m_t % RD;
      ix = (m_t / RD) % 4;
      a = m_act;
      if (w == 0 && ix == 0) a = cargar ? valor : m_pend;
      m_act <= a;
      if (cargar) m_pend <= valor;
      if (w == 0) m_num <= dig_code(a, ix, supr);
      m_t <= m_t + 1;
    end
  end

  task automatic load(input logic [15:0] v);
    cargar = 1'b1; valor = v;
    @(negedge CLK);
    cargar = 1'b0;
  endtask

  task automatic goto_phase(input int ph);
    for (int k = 0; k < 2 * FR && (m_t % FR) != ph; k++) @(negedge CLK);
  endtask

  task automatic test_reset();
    reset = 1'b1; cargar = 1'b0; supr = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      total++;
      if (anodos !== 4'hF || numero !== 4'hF || fin_cuadro !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: anodos=%b numero=%h fin=%b, want 1111 f 0", anodos, numero, fin_cuadro);
      end
    end
    reset = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) @(negedge CLK);
      total++;
      if (k < 3 && anodos !== 4'hF) begin
        bad++; $display("FAIL reset_blank c%0d: anodos=%b want 1111", k, anodos);
      end
      if (k == 3 && (anodos !== 4'b1110 || numero !== 4'h0)) begin
        bad++; $display("FAIL reset_first_show: anodos=%b numero=%h want 1110 0", anodos, numero);
      end
    end
  endtask

  task automatic test_raw();
    logic [3:0] e [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    int fins = 0;
    supr = 1'b0;
    load(16'h1234);
    goto_phase(0);
    for (int c = 0; c < FR; c++) begin
      if (c % RD == BL) begin
        total++;
        if (anodos !== ~(4'b0001 << (c / RD)) || numero !== e[c / RD]) begin
          bad++;
          $display("FAIL raw d%0d: anodos=%b numero=%h want %b %h", c / RD, anodos, numero, ~(4'b0001 << (c / RD)), e[c / RD]);
        end
      end
      if (fin_cuadro === 1'b1) begin
        fins++;
        total++;
        if (c != FR - 1) begin bad++; $display("FAIL fin_pos: pulse at phase %0d want %0d", c, FR - 1); end
      end
      @(negedge CLK);
    end
    total++;
    if (fins != 1) begin bad++; $display("FAIL fin_count: got %0d want 1", fins); end
  endtask

  task automatic test_suppress();
    logic [15:0] pv [2] = '{16'h0050, 16'h0000};
    logic [3:0]  e  [2][4] = '{'{4'h0, 4'h5, 4'hF, 4'hF}, '{4'h0, 4'hF, 4'hF, 4'hF}};
    supr = 1'b1;
    for (int p = 0; p < 2; p++) begin
      load(pv[p]);
      goto_phase(0);
      for (int i = 0; i < 4; i++) begin
        goto_phase(RD * i + BL);
        total++;
        if (numero !== e[p][i]) begin
          bad++; $display("FAIL suppress %h d%0d: numero=%h want %h", pv[p], i, numero, e[p][i]);
        end
      end
    end
    supr = 1'b0;
  endtask

  task automatic test_midframe_load();
    logic [3:0] e [4] = '{4'h8, 4'h7, 4'h6, 4'h5};
    supr = 1'b0;
    load(16'h1234);
    goto_phase(0);
    goto_phase(RD * 2 + 5);
    load(16'h9999);
    total++;
    if (numero !== 4'h2 || anodos !== 4'b1011) begin
      bad++; $display("FAIL mid_old_d2: numero=%h anodos=%b want 2 1011", numero, anodos);
    end
    goto_phase(RD * 3 + BL);
    total++;
    if (numero !== 4'h1) begin bad++; $display("FAIL mid_old_d3: numero=%h want 1", numero); end
    goto_phase(0);
    for (int i = 0; i < 4; i++) begin
      goto_phase(RD * i + BL);
      total++;
      if (numero !== 4'h9) begin bad++; $display("FAIL mid_new d%0d: numero=%h want 9", i, numero); end
    end
    goto_phase(0);
    load(16'h5678);
    for (int i = 0; i < 4; i++) begin
      goto_phase(RD * i + BL);
      total++;
      if (numero !== e[i]) begin bad++; $display("FAIL boundary_load d%0d: numero=%h want %h", i, numero, e[i]); end
    end
  endtask

  task automatic test_reset_mid();
    supr = 1'b0;
    load(16'h1234);
    goto_phase(0);
    goto_phase(RD * 2 + 2);
    load(16'h4321);
    goto_phase(RD * 2 + 5);
    reset = 1'b1;
    @(negedge CLK);
    total++;
    if (anodos !== 4'hF || numero !== 4'hF || fin_cuadro !== 1'b0) begin
      bad++; $display("FAIL reset_mid: anodos=%b numero=%h fin=%b want 1111 f 0", anodos, numero, fin_cuadro);
    end
    reset = 1'b0;
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) @(negedge CLK);
      if (k < 3) begin
        total++;
        if (anodos !== 4'hF) begin bad++; $display("FAIL reset_mid_dark c%0d: anodos=%b want 1111", k, anodos); end
      end
      if (k == 3 || k == 13) begin
        total++;
        if (anodos !== ((k == 3) ? 4'b1110 : 4'b1101) || numero !== 4'h0) begin
          bad++; $display("FAIL reset_mid_show c%0d: anodos=%b numero=%h want digit %0d showing 0", k, anodos, numero, k / RD);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] prev_an, prev_num;
    int same = 0;
    prev_an = anodos; prev_num = numero;
    for (int c = 0; c < 600; c++) begin
      total++;
      if (anodos !== exp_an(m_t) || numero !== m_num || fin_cuadro !== exp_fin(m_t)) begin
        bad++;
        $display("FAIL random t%0d: anodos=%b numero=%h fin=%b want %b %h %b",
                 m_t, anodos, numero, fin_cuadro, exp_an(m_t), m_num, exp_fin(m_t));
      end
      same = (numero === prev_num) ? same + 1 : 0;
      if (anodos !== prev_an && anodos !== 4'hF) begin
        total++;
        if (prev_an !== 4'hF || same < 2) begin
          bad++; $display("FAIL ghost t%0d: prev anodos=%b stable=%0d want 1111 and >=2", m_t, prev_an, same);
        end
      end
      prev_an = anodos; prev_num = numero;
      cargar = ($urandom_range(15) == 0);
      valor = 16'($urandom);
      if ($urandom_range(7) == 0) valor[15:8] = 8'h00;
      if ($urandom_range(49) == 0) supr = ~supr;
      @(negedge CLK);
    end
    cargar = 1'b0;
  endtask

  initial begin
    test_reset();
    test_raw();
    test_suppress();
    test_midframe_load();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
